// File: rtl/lamp_sequence_checker_if.sv
// Light bus between a cyclic lamp and its downstream sequence checker.
// The lamp side (master) drives the colour and the error clear; the checker
// side (slave) returns the registered status.
interface lamp_seq_if #(
   parameter int CNT_W = 8
);
   logic [0:2]       light;
   logic             clr_err;
   logic             seq_err;
   logic [1:0]       err_code;
   logic             err_sticky;
   logic [CNT_W-1:0] cycle_cnt;
   logic             lamp_ok;

   modport master (
      output light, clr_err,
      input  seq_err, err_code, err_sticky, cycle_cnt, lamp_ok
   );

   modport slave (
      input  light, clr_err,
      output seq_err, err_code, err_sticky, cycle_cnt, lamp_ok
   );
endinterface

// File: rtl/lamp_sequence_checker.sv
// Monitors the one-hot RGY lamp bus. It checks that colours step R->G->Y->R
// and that no colour is held for more than MAX_DWELL samples. It also counts
// completed cycles (each Y->R step). All outputs are registered.
//
//  state | meaning
//  SYNC  | no trusted colour yet (after reset or an illegal code / stall)
//  TR    | tracking red
//  TG    | tracking green
//  TY    | tracking yellow
module lamp_sequence_checker #(
   parameter int MAX_DWELL = 4,
   parameter int CNT_W     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   lamp_seq_if.slave   bus
);
   localparam int DW_W = $clog2(MAX_DWELL + 1);

   typedef enum logic [1:0] {SYNC, TR, TG, TY} state_t;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_ILLEGAL = 2'b01;
   localparam logic [1:0] CODE_ORDER   = 2'b10;
   localparam logic [1:0] CODE_STALL   = 2'b11;

   state_t           state_q, state_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic             seq_err_q, err_d;
   logic [1:0]       code_q, code_d, new_code;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ok_q, ok_d;
   state_t           sample_st, next_st;

   // Decode the sampled colour; SYNC stands for an illegal (non one-hot) code.
   always_comb begin
      sample_st = SYNC;
      case (bus.light)
         3'b100:  sample_st = TR;
         3'b010:  sample_st = TG;
         3'b001:  sample_st = TY;
         default: sample_st = SYNC;
      endcase
   end

   // Expected successor of the currently tracked colour.
   always_comb begin
      next_st = SYNC;
      case (state_q)
         TR:      next_st = TG;
         TG:      next_st = TY;
         TY:      next_st = TR;
         default: next_st = SYNC;
      endcase
   end

   // Next state, dwell and error/count updates for this sample.
   always_comb begin
      state_d  = state_q;
      dwell_d  = dwell_q;
      err_d    = 1'b0;
      new_code = CODE_NONE;
      cnt_d    = cnt_q;
      if (state_q == SYNC) begin
         if (sample_st == SYNC) begin
            err_d    = 1'b1;
            new_code = CODE_ILLEGAL;
            dwell_d  = '0;
         end else begin
            state_d = sample_st;
            dwell_d = DW_W'(1);
         end
      end else if (sample_st == SYNC) begin
         err_d    = 1'b1;
         new_code = CODE_ILLEGAL;
         state_d  = SYNC;
         dwell_d  = '0;
      end else if (sample_st == state_q) begin
         if (dwell_q == DW_W'(MAX_DWELL)) begin
            err_d    = 1'b1;
            new_code = CODE_STALL;
            state_d  = SYNC;
            dwell_d  = '0;
         end else begin
            dwell_d = dwell_q + DW_W'(1);
         end
      end else if (sample_st == next_st) begin
         state_d = sample_st;
         dwell_d = DW_W'(1);
         if (state_q == TY) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         err_d    = 1'b1;
         new_code = CODE_ORDER;
         state_d  = sample_st;
         dwell_d  = DW_W'(1);
      end

      // A new error takes precedence over a coincident clear.
      code_d   = code_q;
      sticky_d = sticky_q;
      if (err_d) begin
         code_d   = new_code;
         sticky_d = 1'b1;
      end else if (bus.clr_err) begin
         code_d   = CODE_NONE;
         sticky_d = 1'b0;
      end
      ok_d = (state_d != SYNC) && !sticky_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SYNC;
         dwell_q   <= '0;
         seq_err_q <= 1'b0;
         code_q    <= CODE_NONE;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         seq_err_q <= err_d;
         code_q    <= code_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
         ok_q      <= ok_d;
      end
   end

   assign bus.seq_err    = seq_err_q;
   assign bus.err_code   = code_q;
   assign bus.err_sticky = sticky_q;
   assign bus.cycle_cnt  = cnt_q;
   assign bus.lamp_ok    = ok_q;
endmodule

// File: tb/tb_lamp_sequence_checker.sv
// Bench for lamp_sequence_checker. Two instances are used: one with CNT_W=8
// for the main checks, and one with CNT_W=2 for counter wrap and mid-cycle
// reset. Expected records are queued as each sample is driven. They are
// popped and compared just after the sampling edge.
module tb_lamp_sequence_checker;
   localparam logic [2:0] R   = 3'b100;
   localparam logic [2:0] G   = 3'b010;
   localparam logic [2:0] Y   = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lamp_seq_if #(.CNT_W(8)) bus1 ();
   lamp_seq_if #(.CNT_W(2)) bus2 ();

   lamp_sequence_checker #(.MAX_DWELL(4), .CNT_W(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   lamp_sequence_checker #(.MAX_DWELL(4), .CNT_W(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   typedef struct {
      bit         sel;
      logic [2:0] light;
      logic       clr;
      logic       err;
      logic [1:0] code;
      logic       sticky;
      logic [7:0] cnt;
      logic       ok;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   vec_idx = 0;

   function automatic vec_t v(bit sel, logic [2:0] light, logic clr, logic err,
                              logic [1:0] code, logic sticky, logic [7:0] cnt,
                              logic ok);
      vec_t t;
      t.sel = sel; t.light = light; t.clr = clr; t.err = err;
      t.code = code; t.sticky = sticky; t.cnt = cnt; t.ok = ok;
      return t;
   endfunction

   function automatic logic [12:0] status(bit sel);
      if (sel)
         return {bus2.seq_err, bus2.err_code, bus2.err_sticky,
                 6'd0, bus2.cycle_cnt, bus2.lamp_ok};
      return {bus1.seq_err, bus1.err_code, bus1.err_sticky,
              bus1.cycle_cnt, bus1.lamp_ok};
   endfunction

   task automatic chk(string name, logic [12:0] got, logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {err,code,sticky,cnt,ok}=%h expected %h", name, got, exp);
      end
   endtask

   task automatic apply(vec_t t);
      vec_t e;
      @(negedge clk);
      if (t.sel) begin
         bus2.light = t.light; bus2.clr_err = t.clr;
      end else begin
         bus1.light = t.light; bus1.clr_err = t.clr;
      end
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("dut%0d vec %0d light=%b clr=%b", e.sel ? 2 : 1, vec_idx, e.light, e.clr),
          status(e.sel), {e.err, e.code, e.sticky, e.cnt, e.ok});
      vec_idx++;
   endtask

   initial begin
      bus1.light = OFF; bus1.clr_err = 1'b0;
      bus2.light = R;   bus2.clr_err = 1'b0;

      // Reset release, normal stepping, then the main error scenarios.
      vecs.push_back(v(0, R, 0, 0, 2'b00, 0, 8'd0, 1));
      vecs.push_back(v(0, G, 0, 0, 2'b00, 0, 8'd0, 1));
      vecs.push_back(v(0, Y, 0, 0, 2'b00, 0, 8'd0, 1));
      vecs.push_back(v(0, R, 0, 0, 2'b00, 0, 8'd1, 1));
      vecs.push_back(v(0, G, 0, 0, 2'b00, 0, 8'd1, 1));
      vecs.push_back(v(0, Y, 0, 0, 2'b00, 0, 8'd1, 1));
      vecs.push_back(v(0, R, 0, 0, 2'b00, 0, 8'd2, 1));
      vecs.push_back(v(0, G, 0, 0, 2'b00, 0, 8'd2, 1));
      vecs.push_back(v(0, Y, 0, 0, 2'b00, 0, 8'd2, 1));
      // multi-hot from TG
      vecs.push_back(v(0, R, 0, 0, 2'b00, 0, 8'd3, 1));
      vecs.push_back(v(0, G, 0, 0, 2'b00, 0, 8'd3, 1));
      vecs.push_back(v(0, 3'b110, 0, 1, 2'b01, 1, 8'd3, 0));
      vecs.push_back(v(0, R, 0, 0, 2'b01, 1, 8'd3, 0));
      // skip green: order error, then Y->R still counts
      vecs.push_back(v(0, Y, 0, 1, 2'b10, 1, 8'd3, 0));
      vecs.push_back(v(0, R, 0, 0, 2'b10, 1, 8'd4, 0));
      // green held: 4 samples allowed, 5th is a stall
      vecs.push_back(v(0, G, 0, 0, 2'b10, 1, 8'd4, 0));
      vecs.push_back(v(0, G, 0, 0, 2'b10, 1, 8'd4, 0));
      vecs.push_back(v(0, G, 0, 0, 2'b10, 1, 8'd4, 0));
      vecs.push_back(v(0, G, 0, 0, 2'b10, 1, 8'd4, 0));
      vecs.push_back(v(0, G, 0, 1, 2'b11, 1, 8'd4, 0));
      vecs.push_back(v(0, G, 0, 0, 2'b11, 1, 8'd4, 0));
      // clear with clean samples, then clear colliding with an error
      vecs.push_back(v(0, Y, 1, 0, 2'b00, 0, 8'd4, 1));
      vecs.push_back(v(0, R, 1, 0, 2'b00, 0, 8'd5, 1));
      vecs.push_back(v(0, OFF, 1, 1, 2'b01, 1, 8'd5, 0));
      vecs.push_back(v(0, 3'b111, 0, 1, 2'b01, 1, 8'd5, 0));
      vecs.push_back(v(0, 3'b011, 0, 1, 2'b01, 1, 8'd5, 0));
      vecs.push_back(v(0, R, 1, 0, 2'b00, 0, 8'd5, 1));
      // backwards step G->R is an order error and does not count
      vecs.push_back(v(0, G, 0, 0, 2'b00, 0, 8'd5, 1));
      vecs.push_back(v(0, R, 0, 1, 2'b10, 1, 8'd5, 0));
      vecs.push_back(v(0, G, 1, 0, 2'b00, 0, 8'd5, 1));

      #12;
      chk("reset dut1", status(0), 13'd0);
      chk("reset dut2", status(1), 13'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Counter wrap on the 2-bit instance.
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("reset again dut2", status(1), 13'd0);
      rst_n = 1'b1;
      apply(v(1, R, 0, 0, 2'b00, 0, 8'd0, 1));
      for (int c = 1; c <= 5; c++) begin
         apply(v(1, G, 0, 0, 2'b00, 0, 8'((c - 1) % 4), 1));
         apply(v(1, Y, 0, 0, 2'b00, 0, 8'((c - 1) % 4), 1));
         apply(v(1, R, 0, 0, 2'b00, 0, 8'(c % 4), 1));
      end
      apply(v(1, G, 0, 0, 2'b00, 0, 8'd1, 1));
      apply(v(1, OFF, 0, 1, 2'b01, 1, 8'd1, 0));
      apply(v(1, Y, 0, 0, 2'b01, 1, 8'd1, 0));

      // Reset between edges: outputs drop at once, and the first sample after release only syncs.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async reset dut2", status(1), 13'd0);
      #1 rst_n = 1'b1;
      apply(v(1, G, 0, 0, 2'b00, 0, 8'd0, 1));
      apply(v(1, Y, 0, 0, 2'b00, 0, 8'd0, 1));
      apply(v(1, R, 0, 0, 2'b00, 0, 8'd1, 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
